// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and defaults for the multiplier scheduler
// Contents:
//   WIDTH_DEF / FBITS_DEF  default magnitude width and fraction bits
//   state_e                scheduler states IDLE, START, BUSY, DONE
//   timeout_default()      default watchdog limit for a given magnitude width
//   operand_t              sign + magnitude view of a default-width operand
package mult_pkg;

  localparam int WIDTH_DEF = 15;
  localparam int FBITS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A healthy multiplier finishes in about WIDTH+2 cycles; twice that plus
  // margin leaves room for slower implementations before declaring a hang.
  function automatic int timeout_default(input int width);
    return 2 * width + 8;
  endfunction

  typedef struct packed {
    logic                 sign;
    logic [WIDTH_DEF-1:0] mag;
  } operand_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Ports:
//   req_i    request vector
//   ptr_i    index with highest priority this round
//   grant_o  one-hot grant, zero when no request
//   any_o    at least one request is pending
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic            any_o
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] gnt_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   gnt_rot;

  always_comb begin
    // Rotate so the pointer position lands on bit 0, pick the lowest set
    // bit, then rotate the one-hot result back to requester numbering.
    req_dbl = {req_i, req_i} >> ptr_i;
    req_rot = req_dbl[NREQ-1:0];
    gnt_rot = req_rot & (~req_rot + ONE);
    gnt_dbl = {gnt_rot, gnt_rot} << ptr_i;
    grant_o = gnt_dbl[2*NREQ-1:NREQ];
    any_o   = |req_i;
  end

endmodule

// File: rtl/mult_scheduler.sv
// rtl/mult_scheduler.sv - round-robin sharing of one sequential multiplier
// Ports:
//   clk_i, Reset_i              clock, asynchronous active-high reset
//   req_i                       level request per requester, held until done
//   in1_i, in2_i                flattened operands, requester k at [k*(WIDTH+1) +: WIDTH+1]
//   result_o                    shared result, valid while any done_o bit is high
//   done_o                      one-cycle completion pulse for the served requester
//   grant_o                     one-hot owner of the multiplier, zero when idle
//   error_o                     sticky multiplier timeout flag
//   mult_en_o, mult_in1_o/2_o   enable and operands towards the multiplier
//   mult_out_i, mult_finish_i   result and finish handshake from the multiplier
module mult_scheduler
  import mult_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int FBITS   = FBITS_DEF,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = timeout_default(WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      Reset_i,
  input  logic [NREQ-1:0]           req_i,
  input  logic [NREQ*(WIDTH+1)-1:0] in1_i,
  input  logic [NREQ*(WIDTH+1)-1:0] in2_i,
  output logic [WIDTH:0]            result_o,
  output logic [NREQ-1:0]           done_o,
  output logic [NREQ-1:0]           grant_o,
  output logic                      error_o,
  output logic                      mult_en_o,
  output logic [WIDTH:0]            mult_in1_o,
  output logic [WIDTH:0]            mult_in2_o,
  input  logic [WIDTH:0]            mult_out_i,
  input  logic                      mult_finish_i
);

  localparam int OW  = WIDTH + 1;
  localparam int PW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("mult_scheduler: NREQ must be within 2..8");
  end
  if (FBITS < 0 || FBITS > WIDTH) begin : g_bad_fbits
    $error("mult_scheduler: FBITS must be within 0..WIDTH");
  end

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [OW-1:0]   op1_q, op1_d;
  logic [OW-1:0]   op2_q, op2_d;
  logic [OW-1:0]   result_q, result_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            en_q, en_d;
  logic            error_q, error_d;

  logic [NREQ-1:0] arb_grant;
  logic            arb_any;
  logic [PW-1:0]   win_idx;
  logic [OW-1:0]   op1_sel;
  logic [OW-1:0]   op2_sel;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  // Winner index and its operands, selected from the one-hot grant.
  always_comb begin
    win_idx = '0;
    op1_sel = '0;
    op2_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_grant[k]) begin
        win_idx = PW'(k);
        op1_sel = in1_i[k*OW +: OW];
        op2_sel = in2_i[k*OW +: OW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wd_d     = wd_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    done_d   = '0;
    grant_d  = grant_q;
    en_d     = 1'b0;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          op1_d   = op1_sel;
          op2_d   = op2_sel;
          grant_d = arb_grant;
          ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
          en_d    = 1'b1;   // enable is registered, so it is high during START
          state_d = START;
        end
      end

      START: begin
        wd_d    = '0;
        state_d = BUSY;
      end

      BUSY: begin
        if (mult_finish_i) begin
          result_d = mult_out_i;
          done_d   = grant_q;
          state_d  = DONE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th BUSY cycle without a finish.
          error_d  = 1'b1;
          result_d = '0;
          done_d   = grant_q;
          state_d  = DONE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end

      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wd_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      done_q   <= '0;
      grant_q  <= '0;
      en_q     <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wd_q     <= wd_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      done_q   <= done_d;
      grant_q  <= grant_d;
      en_q     <= en_d;
      error_q  <= error_d;
    end
  end

  assign result_o   = result_q;
  assign done_o     = done_q;
  assign grant_o    = grant_q;
  assign error_o    = error_q;
  assign mult_en_o  = en_q;
  assign mult_in1_o = op1_q;
  assign mult_in2_o = op2_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// tb/tb_mult_scheduler.sv - self-checking bench for mult_scheduler
module tb_mult_scheduler;

  localparam int WIDTH   = 15;
  localparam int FBITS   = 10;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 2 * WIDTH + 8;
  localparam int OW      = WIDTH + 1;

  logic                 clk_i = 1'b0;
  logic                 Reset_i;
  logic [NREQ-1:0]      req_i;
  logic [NREQ*OW-1:0]   in1_i;
  logic [NREQ*OW-1:0]   in2_i;
  logic [OW-1:0]        result_o;
  logic [NREQ-1:0]      done_o;
  logic [NREQ-1:0]      grant_o;
  logic                 error_o;
  logic                 mult_en_o;
  logic [OW-1:0]        mult_in1_o;
  logic [OW-1:0]        mult_in2_o;
  logic [OW-1:0]        mult_out_i;
  logic                 mult_finish_i;

  int checks = 0;
  int errors = 0;
  int rp     = 0;    // reference round-robin pointer
  bit err_exp = 1'b0;
  bit hang   = 1'b0; // multiplier model never finishes while set

  bit m_busy;
  int m_cnt;

  mult_scheduler #(
    .WIDTH   (WIDTH),
    .FBITS   (FBITS),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i         (clk_i),
    .Reset_i       (Reset_i),
    .req_i         (req_i),
    .in1_i         (in1_i),
    .in2_i         (in2_i),
    .result_o      (result_o),
    .done_o        (done_o),
    .grant_o       (grant_o),
    .error_o       (error_o),
    .mult_en_o     (mult_en_o),
    .mult_in1_o    (mult_in1_o),
    .mult_in2_o    (mult_in2_o),
    .mult_out_i    (mult_out_i),
    .mult_finish_i (mult_finish_i)
  );

  always #5 clk_i = ~clk_i;

  // Sign-magnitude fixed-point product, truncated to WIDTH magnitude bits.
  function automatic logic [OW-1:0] fx_mul(input logic [OW-1:0] a, input logic [OW-1:0] b);
    longint unsigned p;
    p = (longint'(a[WIDTH-1:0]) * longint'(b[WIDTH-1:0])) >> FBITS;
    return {a[WIDTH] ^ b[WIDTH], p[WIDTH-1:0]};
  endfunction

  // First requester at or after pointer p, wrapping; -1 when none.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Sequential multiplier: accepts enable at a clock edge, raises finish
  // during its 17th busy cycle, computing from the operands it sees then.
  always @(posedge clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      m_busy        <= 1'b0;
      m_cnt         <= 0;
      mult_finish_i <= 1'b0;
      mult_out_i    <= '0;
    end else if (mult_en_o) begin
      m_busy        <= 1'b1;
      m_cnt         <= 0;
      mult_finish_i <= 1'b0;
    end else if (m_busy) begin
      if (mult_finish_i) begin
        m_busy        <= 1'b0;
        mult_finish_i <= 1'b0;
      end else if (!hang && m_cnt == WIDTH) begin
        mult_finish_i <= 1'b1;
        mult_out_i    <= fx_mul(mult_in1_o, mult_in2_o);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One complete operation starting from an IDLE cycle with requests driven.
  task automatic serve(input bit do_hang, input bit scramble, input bit drop,
                       input bit keep, output int w);
    logic [OW-1:0] ea, eb, er;
    int  n;
    bit  got;
    w = pick(req_i, rp);
    if (w < 0) begin
      check("serve_request_pending", 64'(req_i), 64'(1));
      return;
    end
    ea = in1_i[w*OW +: OW];
    eb = in2_i[w*OW +: OW];
    er = do_hang ? '0 : fx_mul(ea, eb);
    if (do_hang) err_exp = 1'b1;
    rp   = (w + 1) % NREQ;
    hang = do_hang;
    tick();
    check("grant_onehot", 64'(grant_o), 64'(1 << w));
    check("mult_en_start", 64'(mult_en_o), 64'(1));
    check("mult_operands", 64'({mult_in1_o, mult_in2_o}), 64'({ea, eb}));
    n   = 0;
    got = 1'b0;
    while (n < TIMEOUT + 10 && !got) begin
      tick();
      n++;
      if (n == 1) check("mult_en_busy", 64'(mult_en_o), 64'(0));
      if (n == 2 && drop) req_i[w] = 1'b0;
      if (n == 3 && scramble) begin
        in1_i[w*OW +: OW] = OW'($urandom);
        in2_i[w*OW +: OW] = OW'($urandom);
      end
      if (done_o != '0) got = 1'b1;
    end
    check("done_latency", 64'(n), do_hang ? 64'(TIMEOUT + 1) : 64'(WIDTH + 3));
    check("done_onehot", 64'(done_o), 64'(1 << w));
    check("result", 64'(result_o), 64'(er));
    check("error_flag", 64'(error_o), 64'(err_exp));
    if (!keep) req_i[w] = 1'b0;
    hang = 1'b0;
    tick();
    check("done_cleared", 64'(done_o), 64'(0));
    check("grant_cleared", 64'(grant_o), 64'(0));
    check("result_hold", 64'(result_o), 64'(er));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1);
  end

  initial begin
    int w;
    bit sc, dr, kp;

    Reset_i = 1'b1;
    req_i   = '0;
    in1_i   = '0;
    in2_i   = '0;
    repeat (3) tick();
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_en", 64'(mult_en_o), 64'(0));
    check("rst_error", 64'(error_o), 64'(0));
    check("rst_result", 64'(result_o), 64'(0));
    check("rst_operands", 64'({mult_in1_o, mult_in2_o}), 64'(0));
    Reset_i = 1'b0;
    repeat (2) tick();
    check("idle_no_grant", 64'(grant_o), 64'(0));

    // Single request: +1.0 * +3.0
    req_i[0]     = 1'b1;
    in1_i[0 +: OW] = 16'h0400;
    in2_i[0 +: OW] = 16'h0C00;
    serve(1'b0, 1'b0, 1'b0, 1'b0, w);
    check("single_result", 64'(result_o), 64'(16'h0C00));

    // Sign handling: -2.0 * +1.5
    req_i[2]        = 1'b1;
    in1_i[2*OW +: OW] = 16'h8800;
    in2_i[2*OW +: OW] = 16'h0600;
    serve(1'b0, 1'b0, 1'b0, 1'b0, w);
    check("sign_result", 64'(result_o), 64'(16'h8C00));

    // Contention: all requesters held, operands refreshed after each done.
    for (int k = 0; k < NREQ; k++) begin
      in1_i[k*OW +: OW] = OW'($urandom);
      in2_i[k*OW +: OW] = OW'($urandom);
    end
    req_i = '1;
    for (int i = 0; i < 2 * NREQ; i++) begin
      serve(1'b0, 1'b0, 1'b0, 1'b1, w);
      in1_i[w*OW +: OW] = OW'($urandom);
      in2_i[w*OW +: OW] = OW'($urandom);
    end

    // Operand isolation on an explicit single request.
    req_i = '0;
    tick();
    req_i[1] = 1'b1;
    serve(1'b0, 1'b1, 1'b0, 1'b0, w);

    // Random request patterns, operand changes and early request drops.
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        in1_i[k*OW +: OW] = OW'($urandom);
        in2_i[k*OW +: OW] = OW'($urandom);
      end
      req_i = req_i | NREQ'($urandom);
      if (req_i == '0) req_i[$urandom_range(0, NREQ - 1)] = 1'b1;
      sc = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) == 0);
      kp = 1'($urandom_range(0, 1));
      serve(1'b0, sc, dr, kp, w);
    end

    // Timeout: multiplier never finishes, then the next request is served.
    req_i = '0;
    tick();
    req_i[3]          = 1'b1;
    in1_i[3*OW +: OW] = OW'($urandom);
    in2_i[3*OW +: OW] = OW'($urandom);
    serve(1'b1, 1'b0, 1'b0, 1'b0, w);
    req_i[0]        = 1'b1;
    in1_i[0 +: OW]  = OW'($urandom);
    in2_i[0 +: OW]  = OW'($urandom);
    serve(1'b0, 1'b0, 1'b0, 1'b0, w);

    // Reset during BUSY with the pointer away from zero.
    req_i[1] = 1'b1;
    serve(1'b0, 1'b0, 1'b0, 1'b0, w);
    req_i = '1;
    repeat (4) tick();
    #3;
    Reset_i = 1'b1;
    #1;
    check("midrst_grant", 64'(grant_o), 64'(0));
    check("midrst_done", 64'(done_o), 64'(0));
    check("midrst_en", 64'(mult_en_o), 64'(0));
    check("midrst_error", 64'(error_o), 64'(0));
    tick();
    check("midrst_done_held", 64'(done_o), 64'(0));
    Reset_i = 1'b0;
    rp      = 0;
    err_exp = 1'b0;
    serve(1'b0, 1'b0, 1'b0, 1'b0, w);
    check("post_reset_winner", 64'(w), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
- Shares one sequential sign-magnitude fixed-point multiplier (Mult, WIDTH+1-bit operands, FBITS fraction bits, finish_o handshake) between NREQ requesters. Typical requesters are the position, speed and current loops of the actuator controller.
- Round-robin arbitration; latches the winner's operands; sequences the multiplier's enable/finish handshake.
- Returns the result with a per-requester done pulse, and flags a multiplier that never finishes.

Parameters:
- WIDTH, 15, magnitude width; operands and results are WIDTH+1 bits, bit WIDTH is the sign.
- FBITS, 10, fraction bits; passed through to the multiplier instance.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 2*WIDTH+8, maximum cycles in BUSY before the error abort.

Ports:
- clk_i  in  1  system clock
- Reset_i  in  1  reset, asynchronous, active-high
- req_i  in  NREQ  request per requester; level, held until that requester's done
- in1_i  in  NREQ*(WIDTH+1)  multiplicand per requester, flattened; requester k occupies bits [k*(WIDTH+1) +: WIDTH+1]
- in2_i  in  NREQ*(WIDTH+1)  multiplier per requester, same packing as in1_i
- result_o  out  WIDTH+1  shared result bus; valid while any done_o bit is high
- done_o  out  NREQ  one-cycle completion pulse for the served requester
- grant_o  out  NREQ  one-hot owner of the multiplier; zero when idle
- error_o  out  1  sticky timeout flag
- mult_en_o  out  1  to multiplier enable_i
- mult_in1_o  out  WIDTH+1  to multiplier in1_i
- mult_in2_o  out  WIDTH+1  to multiplier in2_i
- mult_out_i  in  WIDTH+1  from multiplier out_o
- mult_finish_i  in  1  from multiplier finish_o

Behaviour:
- Reset (asynchronous, active-high, honoured in any state):
  - State IDLE, round-robin pointer 0, watchdog 0.
  - Operand registers, result_o, done_o, grant_o, mult_en_o and error_o all 0.
  - Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - If any req_i bit is set: pick the first set bit at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's in1/in2 into the operand registers, set grant_o one-hot, go to START.
  - Pointer = winner+1, mod NREQ.
  - No request: stay in IDLE, outputs unchanged except done_o=0.
- START:
  - mult_en_o=1 for exactly this one cycle; watchdog cleared; go to BUSY.
- BUSY:
  - mult_en_o=0.
  - mult_finish_i is low from the first BUSY cycle, because the multiplier accepted enable at the START edge.
  - When mult_finish_i=1: register mult_out_i into result_o and go to DONE.
  - Operands stay driven throughout BUSY, since the multiplier's sign bit is combinational from its inputs.
  - Watchdog increments every BUSY cycle. At TIMEOUT without finish: error_o=1 (sticky until reset), result_o=0, go to DONE.
- DONE:
  - done_o[granted]=1 for one cycle, result_o valid, grant_o cleared at exit; go to IDLE.
  - done_o=0 in every other state.
- Operand and result handling:
  - mult_in1_o/mult_in2_o always come from the operand registers and are held from the grant until the return to IDLE. Requester inputs may change after the grant with no effect.
  - result_o holds its value until the next DONE.
- Requester behaviour:
  - Requester drops req mid-operation: the operation still completes and the done pulse still fires.
  - Requester keeps req high after its done: treated as a new request, arbitrated with the pointer already past it.
- Simultaneous requests: strict round-robin; no requester waits more than NREQ-1 operations.
- Latency with the default WIDTH=15: IDLE grant to done pulse is 20 cycles (1 IDLE + 1 START + 17 BUSY + 1 DONE). Back-to-back throughput is one operation per 20 cycles.

Decomposition:
- Package mult_pkg:
  - WIDTH/FBITS defaults.
  - State enum: IDLE, START, BUSY, DONE.
  - TIMEOUT default function.
  - Operand typedef (sign + WIDTH-bit magnitude).
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, any-request flag.
  - Purely combinational rotate / priority-encode / rotate.

Test Plan:
- Single request: req[0], in1=0x0400 (+1.0), in2=0x0C00 (+3.0) -> done_o[0] pulse 20 cycles after req, result_o=0x0C00.
- Sign handling: req[2], in1=0x8800 (-2.0), in2=0x0600 (+1.5) -> result_o=0x8C00 (-3.0), only done_o[2] pulses.
- Contention: req[3:0]=1111 held continuously -> grants in order 0,1,2,3,0,..., one done per 20 cycles, no requester starved.
- Operand isolation: change in1/in2 of the granted requester 3 cycles after grant -> result reflects the originally latched values.
- Timeout: multiplier model holds finish low forever -> error_o=1 after TIMEOUT BUSY cycles, done_o pulse with result_o=0, next request still served.
- Reset mid-operation: assert Reset_i during BUSY -> grant_o, done_o, mult_en_o and error_o go to 0 immediately with no clock edge, pointer returns to 0, no done pulse.
